pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Hazard and sequencing controller for the five-stage pipelined RISC-V datapath. Generates the stall, flush and forwarding selects consumed by the datapath (StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE). Adds a post-reset boot sequencer that holds the pipeline until the block RAMs are ready. Adds a halt/single-step debug FSM and a saturating load-use stall counter. Sits beside the datapath and control unit in the core top level.

## Interface
Parameters:
- BOOT_CYCLES, 4, minimum cycles spent in BOOT after reset release (≥1)
- CNT_W, 16, width of the load-use stall counter

Ports:
- clk  in  1  core clock (same clock as the pipeline registers)
- resetn  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5 each  source registers in Decode
- Rs1E, Rs2E, RdE  in  5 each  source/destination registers in Execute
- RdM, RdW  in  5 each  destination registers in Memory/Writeback
- RegWriteM, RegWriteW  in  1 each  register-write flags in Memory/Writeback
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch/jump in Execute
- mem_busy  in  1  block RAM reset busy (OR of both rsta_busy)
- halt_req  in  1  level request to freeze the pipeline
- step_req  in  1  pulse/level request for one step while halted
- StallF, StallD  out  1 each  PC / IF-ID register hold
- FlushD, FlushE  out  1 each  IF-ID / ID-EX register clear
- ForwardAE, ForwardBE  out  2 each  Execute operand select: 00 register file, 01 ResultW, 10 ALUResultM
- running  out  1  FSM in RUN
- halted  out  1  FSM in HALT
- step_ack  out  1  high for the single STEP cycle
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- FSM states: BOOT, RUN, HALT, STEP. Reset enters BOOT.
- BOOT: boot counter loaded with BOOT_CYCLES-1 and decremented each cycle, stopping at 0. Go to RUN when counter==0 and mem_busy==0. Outputs: StallF=StallD=FlushD=FlushE=1.
- RUN: hazard logic active.
  - Go to HALT when halt_req=1 and PCSrcE=0.
  - If PCSrcE=1, defer the transition so the redirect is never lost.
- HALT: StallF=StallD=1, FlushE=1, FlushD=0. Bubbles enter E while M/W drain.
  - halt_req=0 → RUN (release wins over step_req).
  - halt_req=1 and step_req=1 → STEP.
- STEP: exactly one cycle with hazard logic active, then unconditionally return to HALT. step_ack=1 only in STEP.
- Hazard logic (RUN/STEP, combinational):
  - ForwardAE = 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W.
  - ForwardBE is the same with Rs2E.
  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & !PCSrcE.
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- In BOOT and HALT, forwarding selects are forced to 00.
- stall_count increments on every clock edge where the FSM is in RUN or STEP and lwStall=1. It saturates at all-ones and never wraps. It clears only on reset.

## Timing
- Reset values: state BOOT, running=0, halted=0, step_ack=0, stall_count=0, StallF=StallD=FlushD=FlushE=1, ForwardAE=ForwardBE=00.
- resetn assertion mid-operation returns to BOOT immediately (asynchronously). The boot counter is reloaded.
- running, halted and step_ack are registered state decodes, valid the cycle after the transition edge.
- Stall, flush and forward outputs are combinational from inputs and current state, with zero-cycle latency.
- With mem_busy=0, running rises BOOT_CYCLES edges after resetn deasserts. Any mem_busy=1 at count 0 extends BOOT.
- halt_req seen in RUN with PCSrcE=0: halted=1 after one edge. If PCSrcE=1 on that cycle, entry to HALT is delayed by one cycle.
- Each STEP advances F/D by at most one instruction. A load-use hazard during STEP consumes the step as a stall.

## Test plan
- Reset, BOOT_CYCLES=4, mem_busy=0 → all stall/flush=1 for 4 cycles, running=1 at edge 4. Holding mem_busy=1 until cycle 7 → running at edge 8.
- RUN, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=5 → ForwardAE=ForwardBE=10. Set RdM=0 → 01. Set RegWriteW=0 → 00.
- Load in E with RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle, and stall_count goes 0→1. Same case with RdE=0 → no stall.
- PCSrcE=1 while halt_req=1 in RUN → FlushD=FlushE=1, halted rises only the cycle after PCSrcE drops.
- HALT, step_req pulsed 3 times → exactly 3 step_ack pulses, each followed by halted=1. Drop halt_req → running=1 next cycle.
- CNT_W=2, 5 consecutive load-use stalls → stall_count reads 1,2,3,3,3. Assert resetn low mid-stall → stall_count=0 immediately, state BOOT.

Source files
------------

// File: rtl/pipeline_controller_if.sv
// Hazard/debug signal bundle between the datapath/control unit and pipeline_controller.
// Latency: none (wires only); the controller drives stall/flush/forward combinationally.
// Backpressure: none; stalls and flushes are the datapath's only flow control.
interface pipeline_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             mem_busy;
    logic             halt_req;
    logic             step_req;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             running;
    logic             halted;
    logic             step_ack;
    logic [CNT_W-1:0] stall_count;

    // Datapath / core-top side.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        output mem_busy, halt_req, step_req,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        input  running, halted, step_ack, stall_count
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        input  mem_busy, halt_req, step_req,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        output running, halted, step_ack, stall_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// Hazard unit plus boot sequencer, halt/single-step FSM and saturating load-use stall counter.
// Latency: stall/flush/forward are combinational (0 cycles); running/halted/step_ack are registered (1 cycle).
// Backpressure: holds F/D (StallF/StallD) and bubbles E (FlushE) during boot, halt and load-use hazards.
module pipeline_controller #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    pipeline_controller_if.slave bus
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT, STEP} state_t;

    state_t           state;
    logic [BW-1:0]    boot_cnt;
    logic             running_q;
    logic             halted_q;
    logic             step_ack_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             lw_stall;
    logic             hazard_active;

    assign hazard_active = (state == RUN) || (state == STEP);

    // A taken branch squashes the instruction in D anyway, so it cancels the load-use stall.
    assign lw_stall = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D)) && !bus.PCSrcE;

    // Forwarding selects: Memory stage result beats Writeback, x0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs1E))
            fwd_a = 2'b10;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs1E))
            fwd_a = 2'b01;
        if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs2E))
            fwd_b = 2'b10;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs2E))
            fwd_b = 2'b01;
    end

    // Stall/flush/forward outputs per state; only RUN and STEP let the hazard logic through.
    always_comb begin
        bus.StallF    = 1'b1;
        bus.StallD    = 1'b1;
        bus.FlushD    = 1'b1;
        bus.FlushE    = 1'b1;
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        case (state)
            BOOT: ;
            HALT: bus.FlushD = 1'b0;
            default: begin
                bus.StallF    = lw_stall;
                bus.StallD    = lw_stall;
                bus.FlushD    = bus.PCSrcE;
                bus.FlushE    = lw_stall || bus.PCSrcE;
                bus.ForwardAE = fwd_a;
                bus.ForwardBE = fwd_b;
            end
        endcase
    end

    // Boot/run/halt/step sequencing; status flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= BOOT;
            boot_cnt   <= BOOT_LOAD;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            step_ack_q <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt != '0) begin
                        boot_cnt <= boot_cnt - 1'b1;
                    end else if (!bus.mem_busy) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Hold off the halt while a redirect is in E so the new PC is not lost.
                    if (bus.halt_req && !bus.PCSrcE) begin
                        state     <= HALT;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                HALT: begin
                    if (!bus.halt_req) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end else if (bus.step_req) begin
                        state      <= STEP;
                        halted_q   <= 1'b0;
                        step_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= HALT;
                    halted_q   <= 1'b1;
                    step_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of load-use stall cycles taken while the hazard logic is live.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt <= '0;
        else if (hazard_active && lw_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.step_ack    = step_ack_q;
    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: boot, forwarding, load-use, halt/step, counter saturation.
// Latency: checks combinational outputs 1-2 time units after input changes, registered ones after each edge.
// Backpressure: n/a.
module tb_pipeline_controller;
    logic clk;
    logic resetn;
    int   total;
    int   passed;

    pipeline_controller_if #(.CNT_W(16)) b();
    pipeline_controller_if #(.CNT_W(2))  b2();

    pipeline_controller #(.BOOT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .bus(b.slave)
    );
    pipeline_controller #(.BOOT_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .resetn(resetn), .bus(b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic clear_inputs();
        b.Rs1D = 0; b.Rs2D = 0; b.Rs1E = 0; b.Rs2E = 0; b.RdE = 0; b.RdM = 0; b.RdW = 0;
        b.RegWriteM = 0; b.RegWriteW = 0; b.ResultSrcE0 = 0; b.PCSrcE = 0;
        b.mem_busy = 0; b.halt_req = 0; b.step_req = 0;
        b2.Rs1D = 0; b2.Rs2D = 0; b2.Rs1E = 0; b2.Rs2E = 0; b2.RdE = 0; b2.RdM = 0; b2.RdW = 0;
        b2.RegWriteM = 0; b2.RegWriteW = 0; b2.ResultSrcE0 = 0; b2.PCSrcE = 0;
        b2.mem_busy = 0; b2.halt_req = 0; b2.step_req = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        tick(); tick();
        chk("rst_running", b.running, 0);
        chk("rst_halted", b.halted, 0);
        chk("rst_step_ack", b.step_ack, 0);
        chk("rst_stall_count", b.stall_count, 0);
        chk("rst_stall_flush", {b.StallF, b.StallD, b.FlushD, b.FlushE}, 4'b1111);
        chk("rst_forward", {b.ForwardAE, b.ForwardBE}, 4'b0000);
        resetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("boot_running_e%0d", i), b.running, (i == 4) ? 1 : 0);
            chk($sformatf("boot_stallf_e%0d", i), b.StallF, (i < 4) ? 1 : 0);
        end
    endtask

    task automatic test_boot_busy();
        resetn = 1'b0;
        b.mem_busy = 1'b1;
        #1;
        chk("async_reset_running", b.running, 0);
        chk("async_reset_flushd", b.FlushD, 1);
        tick();
        resetn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("busy_running_e%0d", i), b.running, (i == 8) ? 1 : 0);
            if (i == 7) b.mem_busy = 1'b0;
        end
    endtask

    task automatic test_forward();
        b.RdM = 5; b.RegWriteM = 1; b.RdW = 5; b.RegWriteW = 1; b.Rs1E = 5; b.Rs2E = 5;
        #1;
        chk("fwd_m_priority", {b.ForwardAE, b.ForwardBE}, 4'b1010);
        b.RdM = 0;
        #1;
        chk("fwd_w", {b.ForwardAE, b.ForwardBE}, 4'b0101);
        b.RegWriteW = 0;
        #1;
        chk("fwd_none", {b.ForwardAE, b.ForwardBE}, 4'b0000);
        b.RdM = 3; b.Rs1E = 3; b.Rs2E = 4;
        #1;
        chk("fwd_a_only", {b.ForwardAE, b.ForwardBE}, 4'b1000);
        b.RegWriteM = 0; b.RdM = 0; b.RdW = 0; b.Rs1E = 0; b.Rs2E = 0;
    endtask

    task automatic test_load_use();
        b.ResultSrcE0 = 1; b.RdE = 7; b.Rs2D = 7;
        #1;
        chk("lw_stall_flush", {b.StallF, b.StallD, b.FlushD, b.FlushE}, 4'b1101);
        chk("lw_count_before", b.stall_count, 0);
        tick();
        chk("lw_count_after", b.stall_count, 1);
        b.ResultSrcE0 = 0;
        #1;
        chk("lw_released", {b.StallF, b.StallD, b.FlushE}, 3'b000);
        b.ResultSrcE0 = 1; b.RdE = 0; b.Rs2D = 0;
        #1;
        chk("lw_x0_no_stall", {b.StallF, b.StallD, b.FlushE}, 3'b000);
        b.RdE = 7; b.Rs1D = 7; b.PCSrcE = 1;
        #1;
        chk("lw_branch_cancels", {b.StallF, b.StallD, b.FlushD, b.FlushE}, 4'b0011);
        tick();
        chk("lw_branch_no_count", b.stall_count, 1);
        b.ResultSrcE0 = 0; b.RdE = 0; b.Rs1D = 0; b.PCSrcE = 0;
    endtask

    task automatic test_branch_halt();
        b.halt_req = 1; b.PCSrcE = 1;
        #1;
        chk("bh_flush", {b.FlushD, b.FlushE}, 2'b11);
        tick();
        chk("bh_deferred_halted", b.halted, 0);
        chk("bh_deferred_running", b.running, 1);
        b.PCSrcE = 0;
        tick();
        chk("bh_halted", b.halted, 1);
        chk("bh_not_running", b.running, 0);
        b.RdM = 5; b.RegWriteM = 1; b.Rs1E = 5;
        #1;
        chk("halt_outputs", {b.StallF, b.StallD, b.FlushD, b.FlushE}, 4'b1101);
        chk("halt_fwd_forced", b.ForwardAE, 2'b00);
    endtask

    task automatic test_step();
        int acks;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            b.step_req = 1;
            tick();
            b.step_req = 0;
            if (b.step_ack === 1'b1) acks++;
            chk($sformatf("step_halted_low_%0d", i), b.halted, 0);
            chk($sformatf("step_fwd_active_%0d", i), b.ForwardAE, 2'b10);
            tick();
            chk($sformatf("step_back_halt_%0d", i), {b.halted, b.step_ack}, 2'b10);
        end
        chk("step_ack_count", acks, 3);
        b.RegWriteM = 0; b.RdM = 0; b.Rs1E = 0;
        b.halt_req = 0; b.step_req = 1;
        tick();
        b.step_req = 0;
        chk("release_running", b.running, 1);
        chk("release_no_step", {b.halted, b.step_ack}, 2'b00);
    endtask

    task automatic test_saturate();
        b2.ResultSrcE0 = 1; b2.RdE = 7; b2.Rs1D = 7;
        chk("sat_start", b2.stall_count, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_count_%0d", i), b2.stall_count, (i < 3) ? i : 3);
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("sat_reset_count", b2.stall_count, 0);
        chk("sat_reset_boot", {b2.running, b2.StallF, b2.FlushD}, 3'b011);
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        resetn = 1'b0;
        test_reset();
        test_boot_busy();
        test_forward();
        test_load_use();
        test_branch_halt();
        test_step();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
